rns_crt_convert: RTL
====================

RNS_CRT_CONVERT -- requirements
Module: rns_crt_convert

Interface
REQ-001 Parameter CHECK_RANGE, default 1: when 1, residue range checking per REQ-019 is enabled.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  residue pair offered.
REQ-005 in_ready  output  1  block can accept a pair.
REQ-006 in_r129  input  8  residue modulo 129 (legal 0..128).
REQ-007 in_r256  input  8  residue modulo 256 (legal 0..255).
REQ-008 out_valid  output  1  converted result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_data  output  16  binary value X, 0..33023.
REQ-011 out_err  output  1  input residue out of range.

Function
REQ-012 The block SHALL compute X such that X mod 129 = in_r129 and X mod 256 = in_r256, with 0 <= X <= 33023.
REQ-013 The method SHALL be mixed-radix CRT: r2m = in_r256 mod 129; d = (in_r129 - r2m) mod 129; t = (d*64) mod 129; X = in_r256 + 256*t (64 = inverse of 256 mod 129).
REQ-014 The FSM SHALL have states IDLE, REDUCE, DIFF, SCALE, OUT.
REQ-015 Transitions: IDLE->REDUCE on in_valid&in_ready; REDUCE->DIFF->SCALE->OUT unconditionally; OUT->IDLE on out_ready.
REQ-016 in_ready SHALL be 1 only in IDLE; in_r129/in_r256 SHALL be captured into internal registers on the accepting edge.
REQ-017 Latency: a pair accepted at edge N SHALL produce out_valid=1 after edge N+4.
REQ-018 In OUT, out_valid SHALL stay 1 with out_data/out_err stable until out_ready=1; the result is released on that edge, and out_valid SHALL deassert on the same edge.
REQ-019 If CHECK_RANGE=1 and captured in_r129 > 128, out_err SHALL be 1 and out_data SHALL be 0; latency is unchanged.
REQ-020 Input changes while not in IDLE SHALL have no effect.
REQ-021 No back-to-back accept: after OUT->IDLE, at least one IDLE cycle SHALL precede the next accept.
REQ-022 out_valid SHALL be 0 in all states except OUT.
REQ-023 Intermediate widths: r2m 8 bit, d 8 bit, t 8 bit; out_data SHALL be formed by concatenation {t, in_r256}, with no adder.

Reset
REQ-024 Asserting reset SHALL asynchronously force state IDLE, out_valid=0, out_data=0, out_err=0, and all internal registers to 0.
REQ-025 Reset mid-conversion SHALL abort that conversion with no output ever issued for it.
REQ-026 After reset deasserts, in_ready SHALL be 1 from the first clock edge.

Structure
REQ-027 Shared package rns_pkg SHALL hold MOD_A=129, MOD_B=256, INV_B_MOD_A=64, X_MAX=33023 and the state enumeration.
REQ-028 A combinational sub-module rns_mod129_scale SHALL compute t = (d*64) mod 129 for d in 0..128.
REQ-029 rns_mod129_scale SHALL use 128 = -1 mod 129: for even d, t = (129 - d/2) mod 129; for odd d, t = 64 - (d-1)/2.

Verification
REQ-030 (in_r129=5, in_r256=5), out_ready=1 -> out_data=5, out_err=0, out_valid exactly 4 cycles after accept.
REQ-031 (97, 232) -> out_data=1000; (128, 255) -> out_data=33023; (0, 0) -> out_data=0.
REQ-032 (200, 10) with CHECK_RANGE=1 -> out_err=1, out_data=0.
REQ-033 out_ready held 0 for 10 cycles -> out_valid and out_data stable; in_ready=0 throughout; a new in_valid is ignored.
REQ-034 Reset asserted during SCALE -> outputs zero immediately; no stale out_valid follows; the next pair converts correctly.
REQ-035 Exhaustive sweep of all 33024 legal pairs against a reference model -> zero mismatches.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared constants and state encoding for the 129/256 residue-to-binary converter.
package rns_pkg;

   localparam int MOD_A       = 129;
   localparam int MOD_B       = 256;
   localparam int INV_B_MOD_A = 64;
   localparam int X_MAX       = 33023;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REDUCE = 3'd1,
      DIFF   = 3'd2,
      SCALE  = 3'd3,
      OUT    = 3'd4
   } state_t;

endpackage

// File: rtl/rns_mod129_scale.sv
// Combinational t = (d * 64) mod 129, exploiting 128 == -1 (mod 129) so no multiplier is needed.
module rns_mod129_scale
   import rns_pkg::*;
(
   input  logic [7:0] d,
   output logic [7:0] t
);

   logic [7:0] half;

   assign half = {1'b0, d[7:1]};

   // d*64 = (d/2)*128 = -(d/2) for even d; odd d adds one extra 64.
   always_comb begin
      t = '0;
      if (d[0]) begin
         t = 8'(INV_B_MOD_A) - half;
      end else if (d != 8'd0) begin
         t = 8'(MOD_A) - half;
      end
   end

endmodule

// File: rtl/rns_crt_convert.sv
// Residue pair (mod 129, mod 256) to binary converter using a mixed-radix CRT,
// one arithmetic step per state with a registered output handshake.
//
// state  | meaning
// IDLE   | ready for a new residue pair
// REDUCE | r2m = r256 mod 129
// DIFF   | d = (r129 - r2m) mod 129
// SCALE  | t = (d * 64) mod 129
// OUT    | load result, then hold until out_ready
module rns_crt_convert
   import rns_pkg::*;
#(
   parameter bit CHECK_RANGE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_r129,
   input  logic [7:0]  in_r256,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_err
);

   state_t     state_q, state_d;
   logic [7:0] r129_q, r256_q, r2m_q, d_q, t_q;
   logic [7:0] r2m_c, d_c, t_c;
   logic       range_err;
   logic       capture, load_out, release_out;

   rns_mod129_scale u_scale (
      .d (d_q),
      .t (t_c)
   );

   assign r2m_c = (r256_q >= 8'(MOD_A)) ? (r256_q - 8'(MOD_A)) : r256_q;
   // The wrapped 8-bit sum is exact because the true difference lies in 1..128.
   assign d_c   = (r129_q >= r2m_q) ? (r129_q - r2m_q) : (r129_q + 8'(MOD_A) - r2m_q);
   assign range_err = CHECK_RANGE && (r129_q > 8'(MOD_A - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      capture     = 1'b0;
      load_out    = 1'b0;
      release_out = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               capture = 1'b1;
               state_d = REDUCE;
            end
         end
         REDUCE: state_d = DIFF;
         DIFF:   state_d = SCALE;
         SCALE:  state_d = OUT;
         OUT: begin
            // First OUT cycle registers the result; afterwards wait for the consumer.
            if (!out_valid) begin
               load_out = 1'b1;
            end else if (out_ready) begin
               release_out = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r129_q    <= '0;
         r256_q    <= '0;
         r2m_q     <= '0;
         d_q       <= '0;
         t_q       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else begin
         if (capture) begin
            r129_q <= in_r129;
            r256_q <= in_r256;
         end
         if (state_q == REDUCE) r2m_q <= r2m_c;
         if (state_q == DIFF)   d_q   <= d_c;
         if (state_q == SCALE)  t_q   <= t_c;
         if (load_out) begin
            out_valid <= 1'b1;
            out_err   <= range_err;
            out_data  <= range_err ? 16'd0 : {t_q, r256_q};
         end else if (release_out) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
